// File: rtl/array_pack.sv
// array_pack: collects a serial stream of WIDTH-bit elements into one packed
// DIM-element word for a downstream sort network. A short array (in_last
// before the final slot) has its unused upper slots filled with all-ones, so
// the pad elements sink to the top positions under an ascending sort.
module array_pack #(
   parameter int DIM   = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   input  logic                       in_last,
   output logic                       in_ready,
   output logic [DIM*WIDTH-1:0]       pl,
   output logic [$clog2(DIM+1)-1:0]   out_count,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int CNT_W = $clog2(DIM+1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM-1);

   // FILL collects elements, HOLD presents the packed array downstream.
   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0]       state;
   logic [IDX_W-1:0] idx;
   logic             beat;
   logic             done;
   logic [DIM-1:0]   sel;
   logic [DIM-1:0]   pad;

   // Handshake outputs come straight from the state register, so neither
   // ready nor valid has a combinational path from the inputs.
   assign in_ready  = (state == FILL);
   assign out_valid = (state == HOLD);

   assign beat = in_valid && in_ready;
   // An array closes on in_last or when the final slot is written.
   assign done = in_last || (idx == LAST_IDX);

   // Decode the slot being written this beat and the slots above it to pad.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      sel = '0;
      pad = '0;
      for (int i = 0; i < DIM; i++) begin
         sel[i] = (IDX_W'(i) == idx);
         pad[i] = (IDX_W'(i) >  idx);
      end
   end

   // FSM, slot index, packed word and count of real elements.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the packed word is a plain register bank, not a RAM, so it is
      // cleared by reset along with the control state.
      if (!rst_n) begin
         state     <= FILL;
         idx       <= '0;
         pl        <= '0;
         out_count <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every read in this
         // block sees the pre-edge value of idx and state.
         case (state)
            FILL: begin
               if (beat) begin
                  for (int i = 0; i < DIM; i++) begin
                     if (sel[i]) begin
                        pl[i*WIDTH +: WIDTH] <= in_data;
                     end else if (done && pad[i]) begin
                        pl[i*WIDTH +: WIDTH] <= '1;
                     end
                  end
                  if (done) begin
                     idx       <= '0;
                     out_count <= CNT_W'(idx) + CNT_W'(1);
                     state     <= HOLD;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= FILL;
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_array_pack.sv
// Directed self-checking bench for array_pack with DIM=4, WIDTH=8.
module tb_array_pack;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] pl;
   logic [2:0]  out_count;
   logic        out_valid;
   logic        out_ready;

   int checks;
   int errors;

   // Throughput bookkeeping.
   logic       took;
   logic [7:0] acc[$];
   int         last_ov;
   int         ov_cnt;

   array_pack #(.DIM(4), .WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .pl        (pl),
      .out_count (out_count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_beat(input logic [7:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset state.
      #2;
      check("rst_in_ready",  in_ready,  1);
      check("rst_out_valid", out_valid, 0);
      check("rst_pl",        pl,        0);
      check("rst_count",     out_count, 0);
      #1 rst_n = 1'b1;
      #3;

      // Full array.
      do_beat(8'h05, 0);
      do_beat(8'h01, 0);
      do_beat(8'h07, 0);
      check("full_fill_ready", in_ready,  1);
      check("full_fill_valid", out_valid, 0);
      do_beat(8'h03, 0);
      check("full_valid", out_valid, 1);
      check("full_ready", in_ready,  0);
      check("full_pl",    pl,        32'h03070105);
      check("full_count", out_count, 4);
      idle();
      check("full_back_valid", out_valid, 0);
      check("full_back_ready", in_ready,  1);

      // Short array padded with all-ones.
      do_beat(8'h22, 0);
      do_beat(8'h11, 1);
      check("short_valid", out_valid, 1);
      check("short_pl",    pl,        32'hFFFF1122);
      check("short_count", out_count, 2);
      idle();

      // Single element.
      do_beat(8'hAA, 1);
      check("single_valid", out_valid, 1);
      check("single_pl",    pl,        32'hFFFFFFAA);
      check("single_count", out_count, 1);
      idle();

      // Backpressure: inputs toggling in HOLD must not disturb the array.
      out_ready = 1'b0;
      do_beat(8'h01, 0);
      do_beat(8'h02, 0);
      do_beat(8'h03, 0);
      do_beat(8'h04, 0);
      check("bp_pl", pl, 32'h04030201);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = (k % 2 == 0) ? 8'hEE : 8'h55;
         in_last  = k[0];
         idle();
         check("bp_hold_pl",    pl,        32'h04030201);
         check("bp_hold_ready", in_ready,  0);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_count", out_count, 4);
      end
      in_data   = 8'h77;
      in_last   = 1'b0;
      out_ready = 1'b1;
      idle();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("bp_rel_ready", in_ready,  1);
      check("bp_rel_valid", out_valid, 0);
      do_beat(8'h99, 1);
      check("bp_next_pl",    pl,        32'hFFFFFF99);
      check("bp_next_count", out_count, 1);
      out_ready = 1'b1;
      idle();

      // Reset pulsed between clock edges mid-fill.
      do_beat(8'h10, 0);
      do_beat(8'h20, 0);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_pl",    pl,        0);
      check("mid_rst_count", out_count, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_ready", in_ready,  1);
      rst_n = 1'b1;
      do_beat(8'hA1, 0);
      do_beat(8'hB2, 0);
      do_beat(8'hC3, 0);
      do_beat(8'hD4, 0);
      check("post_rst_valid", out_valid, 1);
      check("post_rst_pl",    pl,        32'hD4C3B2A1);
      check("post_rst_count", out_count, 4);
      idle();

      // Throughput: continuous traffic, one array every 5 cycles.
      last_ov   = -1;
      ov_cnt    = 0;
      in_valid  = 1'b1;
      in_last   = 1'b0;
      out_ready = 1'b1;
      in_data   = 8'h40;
      for (int c = 0; c < 20; c++) begin
         took = in_ready;
         @(posedge clk);
         #1;
         if (took) begin
            acc.push_back(in_data);
            in_data = in_data + 8'd1;
         end
         if (out_valid) begin
            check("tp_size",  acc.size(), 4);
            if (acc.size() == 4) begin
               check("tp_pl", pl, {acc[3], acc[2], acc[1], acc[0]});
            end
            check("tp_count", out_count, 4);
            if (last_ov >= 0) begin
               check("tp_spacing", c - last_ov, 5);
            end
            acc.delete();
            last_ov = c;
            ov_cnt++;
         end
      end
      in_valid = 1'b0;
      check("tp_arrays",   ov_cnt,     4);
      check("tp_leftover", acc.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
